multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
//   Datapath -> controller: run, opcode, branch_taken, mem_ready
//   Controller -> datapath: pc_we, ir_we, rf_we, mem_re, mem_we, pc_sel,
//                           wb_sel, alu_a_sel, alu_b_sel, alu_op,
//                           state, illegal, instret
// The master modport is the controller side, and the slave modport is the
// datapath side.
interface multicycle_ctrl_if;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;

    logic        pc_we;
    logic        ir_we;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  run, opcode, branch_taken, mem_ready,
        output pc_we, ir_we, rf_we, mem_re, mem_we,
               pc_sel, wb_sel, alu_a_sel, alu_b_sel, alu_op,
               state, illegal, instret
    );

    modport slave (
        output run, opcode, branch_taken, mem_ready,
        input  pc_we, ir_we, rf_we, mem_re, mem_we,
               pc_sel, wb_sel, alu_a_sel, alu_b_sel, alu_op,
               state, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - multicycle_ctrl_if.master (handshake inputs, strobes, selects,
//           state, sticky illegal flag, retired-instruction counter)
// Strobes and selects decode from the current state, the latched opcode class
// and the live handshake inputs. This lets ir_we and the memory-completion
// pc_we follow mem_ready in the same cycle.
module multicycle_ctrl (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_OP, C_OP_IMM, C_LUI, C_AUIPC, C_LOAD, C_STORE,
        C_BRANCH, C_JAL, C_JALR, C_FENCE, C_BAD
    } class_t;

    state_t      state_q;
    class_t      class_q;
    class_t      decoded_class;
    logic        illegal_q;
    logic [31:0] instret_q;

    logic        pc_we, ir_we, rf_we, mem_re, mem_we, alu_b_sel;
    logic [1:0]  pc_sel, wb_sel, alu_a_sel, alu_op;

    function automatic class_t decode_class(input logic [6:0] opc);
        case (opc)
            7'b0110011: return C_OP;
            7'b0010011: return C_OP_IMM;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0001111: return C_FENCE;
            default:    return C_BAD;
        endcase
    endfunction

    assign decoded_class = decode_class(bus.opcode);

    // Output decode. Reset gates this decode directly, so strobes fall as
    // soon as reset rises, without waiting for the state register.
    always_comb begin
        // NOTE: every output gets a default before the case statement.
        // Without this, a path that leaves one unassigned infers a latch.
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        pc_sel    = 2'd0;
        wb_sel    = 2'd0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    if (bus.run) begin
                        mem_re = 1'b1;
                        ir_we  = bus.mem_ready;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        C_OP:     alu_op = 2'd1;
                        C_OP_IMM: begin alu_b_sel = 1'b1; alu_op = 2'd1; end
                        C_LUI:    begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
                        C_AUIPC,
                        C_JAL:    begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                        C_BRANCH: begin
                            alu_op = 2'd2;
                            pc_we  = 1'b1;
                            pc_sel = bus.branch_taken ? 2'd1 : 2'd0;
                        end
                        C_FENCE:  pc_we = 1'b1;
                        default:  alu_b_sel = 1'b1;   // LOAD, STORE, JALR
                    endcase
                end
                S_MEM: begin
                    if (class_q == C_STORE) begin
                        mem_we = 1'b1;
                        pc_we  = bus.mem_ready;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (class_q)
                        C_LOAD:  wb_sel = 2'd1;
                        C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd1; end
                        C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd2; end
                        default: ;
                    endcase
                end
                default: ;   // DECODE and TRAP drive nothing
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, no matter the order of the statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_OP;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            // pc_we is never high in TRAP, so a trapped core cannot retire.
            if (pc_we)
                instret_q <= instret_q + 32'd1;
            case (state_q)
                S_FETCH:
                    if (bus.run && bus.mem_ready)
                        state_q <= S_DECODE;
                S_DECODE: begin
                    class_q <= decoded_class;
                    if (decoded_class == C_BAD) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC:
                    case (class_q)
                        C_BRANCH, C_FENCE: state_q <= S_FETCH;
                        C_LOAD, C_STORE:   state_q <= S_MEM;
                        default:           state_q <= S_WB;
                    endcase
                S_MEM:
                    if (bus.mem_ready)
                        state_q <= (class_q == C_STORE) ? S_FETCH : S_WB;
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;   // unused codes 6 and 7
            endcase
        end
    end

    assign bus.pc_we     = pc_we;
    assign bus.ir_we     = ir_we;
    assign bus.rf_we     = rf_we;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.pc_sel    = pc_sel;
    assign bus.wb_sel    = wb_sel;
    assign bus.alu_a_sel = alu_a_sel;
    assign bus.alu_b_sel = alu_b_sel;
    assign bus.alu_op    = alu_op;
    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.instret   = instret_q;
endmodule
